// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   GRANT_*     : encodings of the grant status output
//   XS_SEED     : xorshift stall-generator seed
//   xs_next     : one step of the 32-bit xorshift (13, 17, 5)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_IDLE = 2'b00;
    localparam logic [1:0] GRANT_CPU  = 2'b01;
    localparam logic [1:0] GRANT_DBG  = 2'b10;

    localparam logic [31:0] XS_SEED = 32'd314159265;

    function automatic logic [31:0] xs_next(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/mem_stall_gen.sv
// mem_stall_gen: pseudo-random request-gap source for the memory side.
// Only instantiated when MEM_ARB_STALL_EN is defined.
// Ports:
//   clk     in  system clock
//   reset   in  async active-high reset, reloads XS_SEED
//   stall_n out 1 = let mem_valid through this cycle, 0 = insert a gap
module mem_stall_gen
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic stall_n
);

    logic [31:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= XS_SEED;
        else       lfsr <= xs_next(lfsr);
    end

    assign stall_n = lfsr[0];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one 32-bit memory port between
// the CPU native bus and a byte-wide debug (GDB) port. A grant is held until
// its transaction completes; completion is a one-cycle ready/ack pulse.
// Optional feature macro: MEM_ARB_STALL_EN (pseudo-random mem_valid gaps).
// Ports:
//   clk, reset                        clock, async active-high reset
//   cpu_valid/instr/addr/wdata/wstrb  CPU request (wstrb==0 is a read)
//   cpu_ready, cpu_rdata              CPU completion pulse, registered read data
//   dbg_req/we/addr/wdata             debug byte request (any alignment)
//   dbg_ack, dbg_rdata                debug completion pulse, registered read byte
//   mem_valid/addr/wdata/wstrb        memory request (word aligned)
//   mem_ready, mem_rdata              memory completion and read data
//   grant                             status: 00 idle, 01 CPU, 10 debug
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic              cpu_instr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_wdata,
    output logic              dbg_ack,
    output logic [7:0]        dbg_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        grant
);

    arb_state_t state, state_nxt;
    logic       last_grant;   // 1: debug was served most recently
    logic       pick_dbg;
    logic       acc_nxt;
    logic       mem_hs;
    logic       stall_n;

    // cpu_instr is status only; nothing in the datapath depends on it.
    logic unused_ok;
    assign unused_ok = &{1'b0, cpu_instr};

`ifdef MEM_ARB_STALL_EN
    mem_stall_gen u_stall (
        .clk     (clk),
        .reset   (reset),
        .stall_n (stall_n)
    );
`else
    assign stall_n = 1'b1;
`endif

    // Debug wins only if it is alone, or on a tie when the CPU was served last.
    assign pick_dbg = dbg_req && (!cpu_valid || !last_grant);
    assign mem_hs   = mem_valid && mem_ready;
    assign acc_nxt  = (state_nxt == CPU_ACC) || (state_nxt == DBG_ACC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_valid || dbg_req)
                    state_nxt = pick_dbg ? DBG_ACC : CPU_ACC;
            end
            CPU_ACC, DBG_ACC: begin
                if (mem_hs) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_valid is a flop so the memory sees a clean request one cycle after
    // the grant; it falls together with the ACC->DONE transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant      <= GRANT_IDLE;
            mem_valid  <= 1'b0;
            cpu_rdata  <= 32'h0;
            dbg_rdata  <= 8'h0;
        end else begin
            mem_valid <= acc_nxt && stall_n;
            if (state == IDLE && state_nxt != IDLE) begin
                grant      <= pick_dbg ? GRANT_DBG : GRANT_CPU;
                last_grant <= pick_dbg;
            end else if (state == DONE) begin
                grant <= GRANT_IDLE;
            end
            if (state == CPU_ACC && mem_hs)
                cpu_rdata <= mem_rdata;
            if (state == DBG_ACC && mem_hs)
                dbg_rdata <= 8'(mem_rdata >> {dbg_addr[1:0], 3'b000});
        end
    end

    assign cpu_ready = (state == DONE) && (grant == GRANT_CPU);
    assign dbg_ack   = (state == DONE) && (grant == GRANT_DBG);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        case (state)
            CPU_ACC: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wstrb = cpu_wstrb;
            end
            DBG_ACC: begin
                mem_addr  = {dbg_addr[ADDR_W-1:2], 2'b00};
                mem_wdata = {4{dbg_wdata}};
                mem_wstrb = dbg_we ? (4'b0001 << dbg_addr[1:0]) : 4'b0000;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_valid, cpu_instr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [7:0]        dbg_wdata;
    logic              dbg_ack;
    logic [7:0]        dbg_rdata;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [1:0]        grant;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mem [16];

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_valid = 0; cpu_instr = 0; cpu_addr = '0; cpu_wdata = 0; cpu_wstrb = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (2) tick();
        reset = 0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) tick();
        nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL reset_grant: got %b want 00", grant); end
        nvec++; if (cpu_ready !== 1'b0 || dbg_ack !== 1'b0) begin nerr++; $display("FAIL reset_pulses: cpu_ready=%b dbg_ack=%b want 0 0", cpu_ready, dbg_ack); end
        nvec++; if (mem_valid !== 1'b0 || mem_wstrb !== 4'b0) begin nerr++; $display("FAIL reset_mem: mem_valid=%b mem_wstrb=%b want 0 0000", mem_valid, mem_wstrb); end
        nvec++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 8'h0) begin nerr++; $display("FAIL reset_rdata: cpu_rdata=%h dbg_rdata=%h want 0 0", cpu_rdata, dbg_rdata); end
        reset = 0;
        tick();
        nvec++; if (mem_valid !== 1'b0 || grant !== 2'b00) begin nerr++; $display("FAIL reset_release_idle: mem_valid=%b grant=%b want 0 00", mem_valid, grant); end
    endtask

    task automatic test_cpu_read();
        cpu_valid = 1; cpu_instr = 1; cpu_addr = 32'h100; cpu_wstrb = 0; cpu_wdata = 32'h0;
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        nvec++; if (grant !== 2'b01 || mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_wstrb !== 4'b0 || cpu_ready !== 1'b0) begin
            nerr++; $display("FAIL cpu_rd_acc: grant=%b mem_valid=%b mem_addr=%h mem_wstrb=%b cpu_ready=%b want 01 1 00000100 0000 0", grant, mem_valid, mem_addr, mem_wstrb, cpu_ready); end
        tick();
        nvec++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL cpu_rd_done: cpu_ready=%b cpu_rdata=%h want 1 deadbeef", cpu_ready, cpu_rdata); end
        nvec++; if (mem_valid !== 1'b0 || grant !== 2'b01) begin nerr++; $display("FAIL cpu_rd_done_mem: mem_valid=%b grant=%b want 0 01", mem_valid, grant); end
        cpu_valid = 0; mem_ready = 0;
        tick();
        nvec++; if (cpu_ready !== 1'b0 || grant !== 2'b00) begin nerr++; $display("FAIL cpu_rd_idle: cpu_ready=%b grant=%b want 0 00", cpu_ready, grant); end
    endtask

    task automatic test_dbg_write();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h203; dbg_wdata = 8'h5A;
        mem_ready = 0;
        tick();
        nvec++; if (grant !== 2'b10 || mem_valid !== 1'b1) begin nerr++; $display("FAIL dbg_wr_grant: grant=%b mem_valid=%b want 10 1", grant, mem_valid); end
        nvec++; if (mem_addr !== 32'h200 || mem_wstrb !== 4'b1000 || mem_wdata !== 32'h5A5A5A5A) begin
            nerr++; $display("FAIL dbg_wr_bus: addr=%h wstrb=%b wdata=%h want 00000200 1000 5a5a5a5a", mem_addr, mem_wstrb, mem_wdata); end
        mem_ready = 1;
        tick();
        nvec++; if (dbg_ack !== 1'b1 || cpu_ready !== 1'b0 || mem_wstrb !== 4'b0) begin nerr++; $display("FAIL dbg_wr_ack: dbg_ack=%b cpu_ready=%b mem_wstrb=%b want 1 0 0000", dbg_ack, cpu_ready, mem_wstrb); end
        dbg_req = 0; mem_ready = 0;
        tick();
        nvec++; if (dbg_ack !== 1'b0 || grant !== 2'b00) begin nerr++; $display("FAIL dbg_wr_idle: dbg_ack=%b grant=%b want 0 00", dbg_ack, grant); end
    endtask

    task automatic test_dbg_read();
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h101; dbg_wdata = 8'hFF;
        mem_ready = 1; mem_rdata = 32'h11223344;
        tick();
        nvec++; if (mem_addr !== 32'h100 || mem_wstrb !== 4'b0000) begin nerr++; $display("FAIL dbg_rd_bus: addr=%h wstrb=%b want 00000100 0000", mem_addr, mem_wstrb); end
        tick();
        nvec++; if (dbg_ack !== 1'b1 || dbg_rdata !== 8'h33) begin nerr++; $display("FAIL dbg_rd_data: dbg_ack=%b dbg_rdata=%h want 1 33", dbg_ack, dbg_rdata); end
        dbg_req = 0; mem_ready = 0;
        tick();
        nvec++; if (dbg_ack !== 1'b0) begin nerr++; $display("FAIL dbg_rd_single: dbg_ack=%b want 0", dbg_ack); end
    endtask

    task automatic test_tie();
        do_reset();
        cpu_valid = 1; cpu_addr = 32'h10; cpu_wstrb = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h22;
        mem_ready = 1; mem_rdata = 32'hA1B2C3D4;
        tick();
        nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL tie1_grant: got %b want 01", grant); end
        tick();
        nvec++; if (cpu_ready !== 1'b1) begin nerr++; $display("FAIL tie1_ready: got %b want 1", cpu_ready); end
        cpu_valid = 0;
        tick();
        tick();
        nvec++; if (grant !== 2'b10) begin nerr++; $display("FAIL tie1_second: got %b want 10", grant); end
        tick();
        nvec++; if (dbg_ack !== 1'b1 || dbg_rdata !== 8'hB2) begin nerr++; $display("FAIL tie1_ack: dbg_ack=%b dbg_rdata=%h want 1 b2", dbg_ack, dbg_rdata); end
        dbg_req = 0;
        tick();
        cpu_valid = 1; dbg_req = 1;
        tick();
        nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL tie2_grant: got %b want 01", grant); end
        tick();
        cpu_valid = 0;
        tick();
        tick();
        nvec++; if (grant !== 2'b10) begin nerr++; $display("FAIL tie2_second: got %b want 10", grant); end
        tick();
        dbg_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_stall();
        cpu_valid = 1; cpu_addr = 32'h40; cpu_wstrb = 4'b0011; cpu_wdata = 32'h0BADF00D;
        mem_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++; if (grant !== 2'b01 || mem_valid !== 1'b1 || cpu_ready !== 1'b0 || mem_wstrb !== 4'b0011) begin
                nerr++; $display("FAIL stall_hold[%0d]: grant=%b mem_valid=%b cpu_ready=%b wstrb=%b want 01 1 0 0011", i, grant, mem_valid, cpu_ready, mem_wstrb); end
        end
        mem_ready = 1;
        tick();
        nvec++; if (cpu_ready !== 1'b1 || mem_valid !== 1'b0) begin nerr++; $display("FAIL stall_done: cpu_ready=%b mem_valid=%b want 1 0", cpu_ready, mem_valid); end
        cpu_valid = 0; mem_ready = 0;
        tick();
        nvec++; if (cpu_ready !== 1'b0) begin nerr++; $display("FAIL stall_single: cpu_ready=%b want 0", cpu_ready); end
    endtask

    task automatic test_reset_mid();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h7; dbg_wdata = 8'hC3;
        mem_ready = 0;
        tick();
        nvec++; if (grant !== 2'b10 || mem_valid !== 1'b1) begin nerr++; $display("FAIL rstmid_pre: grant=%b mem_valid=%b want 10 1", grant, mem_valid); end
        reset = 1;
        #1;
        nvec++; if (mem_valid !== 1'b0 || grant !== 2'b00 || dbg_ack !== 1'b0 || mem_wstrb !== 4'b0) begin
            nerr++; $display("FAIL rstmid_async: mem_valid=%b grant=%b dbg_ack=%b wstrb=%b want 0 00 0 0000", mem_valid, grant, dbg_ack, mem_wstrb); end
        mem_ready = 1;
        @(negedge clk);
        tick();
        nvec++; if (dbg_ack !== 1'b0 || mem_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_hold: dbg_ack=%b mem_valid=%b want 0 0", dbg_ack, mem_valid); end
        dbg_req = 0; mem_ready = 0;
        reset = 0;
        tick();
        nvec++; if (dbg_ack !== 1'b0 || grant !== 2'b00 || mem_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_after: dbg_ack=%b grant=%b mem_valid=%b want 0 00 0", dbg_ack, grant, mem_valid); end
        cpu_valid = 1; cpu_addr = 32'h8; cpu_wstrb = 0; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        tick();
        nvec++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin nerr++; $display("FAIL rstmid_next: cpu_ready=%b cpu_rdata=%h want 1 cafef00d", cpu_ready, cpu_rdata); end
        cpu_valid = 0; mem_ready = 0;
        tick();
    endtask

    // Transaction-level model: round-robin choice on each grant decision, a
    // 16-word memory image, and the debug lane/strobe arithmetic.
    task automatic test_random();
        logic c_pend, d_pend, c_hs, d_hs, last_d, rc, rd, c_wr, d_we, just_done;
        logic [31:0] c_addr, c_wdata, c_exp, d_addr, ea, ew, word;
        logic [3:0]  c_wstrb, es;
        logic [7:0]  d_wdata, d_exp;
        logic [1:0]  prev_g, exp_g;
        logic [1:0]  owner;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        c_pend = 0; d_pend = 0; c_hs = 0; d_hs = 0; last_d = 1; rc = 0; rd = 0;
        c_wr = 0; d_we = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0; c_exp = 0;
        d_addr = 0; d_wdata = 0; d_exp = 0; prev_g = 2'b00;
        for (int cyc = 0; cyc < 2600; cyc++) begin
            tick();
            if (prev_g == 2'b00) begin
                exp_g = (rc && rd) ? (last_d ? 2'b01 : 2'b10) : rc ? 2'b01 : rd ? 2'b10 : 2'b00;
                nvec++; if (grant !== exp_g) begin nerr++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, grant, exp_g); end
                if (exp_g != 2'b00) last_d = (exp_g == 2'b10);
            end
            nvec++; if (cpu_ready !== c_hs) begin nerr++; $display("FAIL rnd_cpu_ready@%0d: got %b want %b", cyc, cpu_ready, c_hs); end
            nvec++; if (dbg_ack !== d_hs) begin nerr++; $display("FAIL rnd_dbg_ack@%0d: got %b want %b", cyc, dbg_ack, d_hs); end
            just_done = 0;
            if (cpu_ready === 1'b1 && c_hs) begin
                if (!c_wr) begin
                    nvec++; if (cpu_rdata !== c_exp) begin nerr++; $display("FAIL rnd_cpu_rdata@%0d: got %h want %h", cyc, cpu_rdata, c_exp); end
                end
                cpu_valid = 0; c_pend = 0; just_done = 1;
            end
            if (dbg_ack === 1'b1 && d_hs) begin
                if (!d_we) begin
                    nvec++; if (dbg_rdata !== d_exp) begin nerr++; $display("FAIL rnd_dbg_rdata@%0d: got %h want %h", cyc, dbg_rdata, d_exp); end
                end
                dbg_req = 0; d_pend = 0; just_done = 1;
            end
            c_hs = 0; d_hs = 0;
            // memory side: decide mem_ready for the coming edge
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = mem[mem_addr[5:2]];
            if (mem_valid === 1'b1) begin
                owner = 2'b00; ea = 0; ew = 0; es = 0;
                if (grant === 2'b01 && c_pend) begin
                    owner = 2'b01; ea = c_addr; ew = c_wdata; es = c_wstrb;
                end else if (grant === 2'b10 && d_pend) begin
                    owner = 2'b10; ea = d_addr & 32'hFFFF_FFFC; ew = d_wdata * 32'h0101_0101;
                    es = d_we ? 4'(1 << (d_addr % 4)) : 4'b0000;
                end
                nvec++; if (owner == 2'b00) begin nerr++; $display("FAIL rnd_owner@%0d: mem_valid with grant %b, pending cpu=%b dbg=%b", cyc, grant, c_pend, d_pend); end
                else begin
                    nvec++; if ({mem_addr, mem_wdata, mem_wstrb} !== {ea, ew, es}) begin
                        nerr++; $display("FAIL rnd_bus@%0d: addr=%h wdata=%h wstrb=%b want %h %h %b", cyc, mem_addr, mem_wdata, mem_wstrb, ea, ew, es); end
                    if (mem_ready) begin
                        word = mem[ea[5:2]];
                        for (int b = 0; b < 4; b++)
                            if (es[b]) mem[ea[5:2]][8*b +: 8] = ew[8*b +: 8];
                        if (owner == 2'b01) begin c_hs = 1; c_exp = word; end
                        else begin d_hs = 1; d_exp = 8'(word >> (8 * (d_addr % 4))); end
                    end
                end
            end else begin
                nvec++; if (mem_wstrb !== 4'b0000) begin nerr++; $display("FAIL rnd_idle_wstrb@%0d: got %b want 0000", cyc, mem_wstrb); end
            end
            if (!just_done && cyc < 2000) begin
                if (!c_pend && $urandom_range(0, 3) == 0) begin
                    c_pend = 1; c_addr = 32'($urandom_range(0, 15) * 4); c_wdata = $urandom;
                    c_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
                    c_wr = (c_wstrb != 4'b0000);
                    cpu_valid = 1; cpu_addr = c_addr; cpu_wdata = c_wdata; cpu_wstrb = c_wstrb;
                    cpu_instr = 1'($urandom_range(0, 1));
                end
                if (!d_pend && $urandom_range(0, 3) == 0) begin
                    d_pend = 1; d_addr = 32'($urandom_range(0, 63)); d_wdata = 8'($urandom);
                    d_we = 1'($urandom_range(0, 1));
                    dbg_req = 1; dbg_addr = d_addr; dbg_wdata = d_wdata; dbg_we = d_we;
                end
            end
            rc = cpu_valid; rd = dbg_req; prev_g = grant;
            if (cyc >= 2000 && !c_pend && !d_pend && !c_hs && !d_hs) break;
        end
        nvec++; if (c_pend || d_pend) begin nerr++; $display("FAIL rnd_drain: outstanding cpu=%b dbg=%b want 0 0", c_pend, d_pend); end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_dbg_read();
        test_tie();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter for the simulation memory model of the picorv32 GDB-server build. It shares the single 32-bit memory port between the CPU native bus and a byte-wide debug port, which the GDB server uses to peek and poke memory while the core runs. Arbitration is round-robin, and each grant is held until its transaction completes. Optionally, the block injects pseudo-random stalls on the memory side.

## Interface
Parameters:
- ADDR_W, 32, address width for all ports; must be at least 3.

Ports (one clock domain, asynchronous active-high reset):
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  CPU request; held stable until cpu_ready.
- cpu_instr  in  1  instruction fetch flag; status only.
- cpu_addr  in  ADDR_W  CPU byte address, word aligned.
- cpu_wdata  in  32  CPU write data.
- cpu_wstrb  in  4  CPU byte strobes; 0 means read.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  32  registered read data; valid while cpu_ready=1.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  1 means write, 0 means read.
- dbg_addr  in  ADDR_W  debug byte address; any alignment.
- dbg_wdata  in  8  debug write byte.
- dbg_ack  out  1  one-cycle completion pulse to the debug port.
- dbg_rdata  out  8  registered read byte; valid while dbg_ack=1.
- mem_valid  out  1  request to the memory model.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte strobes.
- mem_ready  in  1  memory completion; sampled only while mem_valid=1.
- mem_rdata  in  32  memory read data; valid with mem_ready.
- grant  out  2  status: 00 idle, 01 CPU, 10 debug.

## Operation
- States:
  - IDLE: no grant.
  - CPU_ACC: CPU transaction in flight.
  - DBG_ACC: debug transaction in flight.
  - DONE: completion pulse cycle.
- IDLE to an ACC state:
  - Only one requester: grant it.
  - Both requesting: grant the master not served last (tracked in last_grant).
  - last_grant updates on every grant.
- In CPU_ACC, mem_addr/mem_wdata/mem_wstrb are the CPU inputs.
- In DBG_ACC:
  - mem_addr = {dbg_addr[ADDR_W-1:2], 2'b00}.
  - mem_wdata = dbg_wdata replicated into all four lanes.
  - mem_wstrb = dbg_we ? (4'b0001 << dbg_addr[1:0]) : 4'b0000.
- ACC to DONE: on mem_valid && mem_ready.
  - Latch mem_rdata into cpu_rdata, or latch lane dbg_addr[1:0] into dbg_rdata.
- DONE:
  - Assert cpu_ready or dbg_ack according to grant for exactly one cycle.
  - Then return to IDLE.
- The requester must deassert its request on the edge where it sees ready/ack. A request still high in IDLE is treated as a new transaction.
- Request inputs outside IDLE are ignored by the grant logic. A mid-transaction change to the granted master's address or data is undefined.
- Outside ACC states: mem_valid=0, mem_wstrb=0.

## Timing
- Reset: state=IDLE, last_grant=debug (so the CPU wins the first tie). All outputs are 0: grant=00, cpu_ready=0, dbg_ack=0, mem_valid=0, rdata registers 0.
- mem_valid is registered. With a request at edge n, mem_valid=1 is visible from cycle n+1.
- With mem_ready at edge m, ready/ack=1 during cycle m+1 and the FSM is in IDLE at m+2.
- Minimum latency, request to ready/ack: 2 cycles (no stalls, mem_ready=1 immediately).
- Back-to-back alternating masters have a minimum period of 3 cycles per transaction.
- Reset asserted mid-transaction:
  - Immediately drop mem_valid, ready and ack.
  - Discard the transaction and perform no memory write completion.

## Configuration
- MEM_ARB_STALL_EN defined:
  - A 32-bit xorshift generator (shifts 13, 17, 5; seed 314159265) advances every clock while reset=0 and reloads the seed on reset.
  - In ACC states, mem_valid is gated by lfsr[0], so the memory sees pseudo-random request gaps.
  - The ACC-to-DONE transition requires mem_valid && mem_ready.
- MEM_ARB_STALL_EN undefined: mem_valid=1 for the whole ACC state and no generator logic exists.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, CPU_ACC, DBG_ACC, DONE);
  - the GRANT_* encodings;
  - the XS_SEED = 314159265 constant.
- Sub-module mem_stall_gen holds the xorshift register and exposes a one-bit stall_n. It is instantiated only under MEM_ARB_STALL_EN.

## Test plan
- CPU read only: cpu_addr=0x100, mem_ready=1, mem_rdata=0xDEADBEEF -> cpu_ready pulses 2 cycles after cpu_valid with cpu_rdata=0xDEADBEEF; grant=01 then 00.
- Debug byte write: dbg_addr=0x203, dbg_wdata=0x5A -> mem_addr=0x200, mem_wstrb=4'b1000, mem_wdata=0x5A5A5A5A; dbg_ack one cycle.
- Debug byte read: dbg_addr=0x101, mem_rdata=0x11223344 -> dbg_rdata=0x33.
- Simultaneous cpu_valid and dbg_req from reset -> CPU granted first, debug second. Next tie -> CPU granted again (alternation).
- mem_ready held 0 for 5 cycles -> grant and mem_valid stay stable, no ready/ack. Then mem_ready=1 -> single pulse.
- Reset asserted during DBG_ACC -> mem_valid=0 and grant=00 immediately, no dbg_ack. After release, the next request is served normally (with MEM_ARB_STALL_EN: same mem_valid gap pattern as from first reset).
